// File: rtl/tlb_pkg.sv
// tlb_pkg: shared types and constants for the n-way TLB.
//   FLAG_V / FLAG_G : bit positions of the valid and global flags in an entry's flags byte
//   entry_t         : 4K entry payload (tag, ppn, flags); the ASID is stored beside it
//   flush_state_e   : flush walker states
//   vpn_tag()       : 4K tag of a VPN (its top TAG_W bits)
package tlb_pkg;

   localparam int FLAG_V  = 0;
   localparam int FLAG_G  = 5;
   localparam int TAG_W   = 11;
   localparam int PPN_W   = 17;
   localparam int FLAGS_W = 8;
   localparam int SPPN_W  = 7;   // 4M page frame = ppn[28:22]

   typedef struct packed {
      logic [TAG_W-1:0]   tag;
      logic [PPN_W-1:0]   ppn;
      logic [FLAGS_W-1:0] flags;
   } entry_t;

   typedef enum logic [1:0] {
      FS_IDLE  = 2'd0,
      FS_WALK  = 2'd1,
      FS_DRAIN = 2'd2
   } flush_state_e;

   function automatic logic [TAG_W-1:0] vpn_tag(input logic [19:0] vpn);
      return vpn[19 -: TAG_W];
   endfunction

endpackage

// File: rtl/tlb_nway_plru.sv
// plru_tree: tree pseudo-LRU for one set.
//   tree      : WAYS-1 node bits; node n has children 2n+1 / 2n+2, bit=1 means "victim on the right"
//   access    : binary index of the way just used
//   victim    : one-hot way the tree currently points at
//   tree_next : tree updated so every node on access's path points away from it
module plru_tree #(
   parameter int WAYS = 4
) (
   input  logic [WAYS-2:0]         tree,
   input  logic [$clog2(WAYS)-1:0] access,
   output logic [WAYS-1:0]         victim,
   output logic [WAYS-2:0]         tree_next
);

   localparam int LVL = $clog2(WAYS);

   int   vnode;
   int   unode;
   logic bit_sel;

   always_comb begin
      vnode  = 0;
      victim = '0;
      for (int l = 0; l < LVL; l++) vnode = 2 * vnode + 1 + int'(tree[vnode]);
      victim[vnode - (WAYS - 1)] = 1'b1;
   end

   always_comb begin
      tree_next = tree;
      unode     = 0;
      bit_sel   = 1'b0;
      for (int l = 0; l < LVL; l++) begin
         bit_sel          = access[LVL-1-l];
         tree_next[unode] = ~bit_sel;
         unode            = 2 * unode + 1 + int'(bit_sel);
      end
   end

endmodule

// File: rtl/tlb_nway.sv
// tlb_nway: WAYS-way 4K TLB plus direct-mapped 4M TLB with PLRU replacement and a flush walker.
//   clk, reset                 : clock, asynchronous active-high reset
//   read_req/ready/asid/addr   : lookup; results one cycle after acceptance, held until next accept
//   read_hit/super/ppn/flags   : lookup result (super hit wins over 4K hit)
//   read_way                   : one-hot 4K hit way, else PLRU victim (write target)
//   write_*                    : fill into the set of the last accepted lookup
//   flush_*                    : invalidate by ASID and/or address; flush_busy while walking
//   flush_state                : flush FSM state, for observation
module tlb_nway
   import tlb_pkg::*;
#(
   parameter int WAYS       = 4,
   parameter int SETS       = 512,
   parameter int SUPER_SETS = 1024,
   parameter int ASID_W     = 9
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               read_req,
   output logic               read_ready,
   input  logic [ASID_W-1:0]  read_asid,
   input  logic [31:12]       read_addr,
   output logic               read_hit,
   output logic               read_super,
   output logic [28:12]       read_ppn,
   output logic [7:0]         read_flags,
   output logic [WAYS-1:0]    read_way,
   input  logic               write_req,
   input  logic               write_super,
   input  logic [10:0]        write_tag,
   input  logic [ASID_W-1:0]  write_asid,
   input  logic [28:12]       write_ppn,
   input  logic [7:0]         write_flags,
   input  logic               flush_req,
   input  logic               flush_asid_en,
   input  logic [ASID_W-1:0]  flush_asid,
   input  logic               flush_addr_en,
   input  logic [31:12]       flush_addr,
   output logic               flush_busy,
   output flush_state_e       flush_state
);

   localparam int SET_W  = $clog2(SETS);
   localparam int SUP_W  = $clog2(SUPER_SETS);
   localparam int WAY_W  = $clog2(WAYS);
   localparam int WALK_N = (SETS > SUPER_SETS) ? SETS : SUPER_SETS;
   localparam int WALK_W = $clog2(WALK_N);

   // Handshake: a lookup transfers on a cycle with read_req & read_ready; read_ready is low
   // for the whole flush, and writes are dropped during that time as well.
   logic read_acc, write_acc;
   assign read_ready = ~flush_busy;
   assign read_acc   = read_req & read_ready;
   assign write_acc  = write_req & ~flush_busy;

   // Storage: valid bits and PLRU in flops, payload in RAM
   entry_t              ram4k  [SETS][WAYS];
   logic [ASID_W-1:0]   asid4k [SETS][WAYS];
   logic [SPPN_W-1:0]   sup_ppn   [SUPER_SETS];
   logic [FLAGS_W-1:0]  sup_flags [SUPER_SETS];
   logic [ASID_W-1:0]   sup_asid  [SUPER_SETS];
   logic [WAYS-1:0]     valid4k [SETS];
   logic [SUPER_SETS-1:0] valid_s;
   logic [WAYS-2:0]     plru [SETS];

   logic [SET_W-1:0] rd_set_idx;
   logic [SUP_W-1:0] rd_sup_idx;
   assign rd_set_idx = read_addr[12 +: SET_W];
   assign rd_sup_idx = read_addr[22 +: SUP_W];

   // Lookup snapshot: everything the result depends on is captured at acceptance, so the
   // outputs hold steady across later writes, flushes and PLRU updates.
   logic              result_valid, result_new;
   logic [WAYS-1:0]   lk_valid_set;
   logic              lk_valid_sup;
   logic [WAYS-2:0]   lk_plru;
   logic [ASID_W-1:0] lk_asid;
   logic [TAG_W-1:0]  lk_tag;
   logic [SET_W-1:0]  lk_set;
   logic [SUP_W-1:0]  lk_sup;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_valid <= 1'b0;
         result_new   <= 1'b0;
         lk_valid_set <= '0;
         lk_valid_sup <= 1'b0;
         lk_plru      <= '0;
         lk_asid      <= '0;
         lk_tag       <= '0;
         lk_set       <= '0;
         lk_sup       <= '0;
      end else begin
         result_new <= read_acc;
         if (read_acc) begin
            result_valid <= 1'b1;
            lk_valid_set <= valid4k[rd_set_idx];
            lk_valid_sup <= valid_s[rd_sup_idx];
            lk_plru      <= plru[rd_set_idx];
            lk_asid      <= read_asid;
            lk_tag       <= vpn_tag(read_addr);
            lk_set       <= rd_set_idx;
            lk_sup       <= rd_sup_idx;
         end
      end
   end

   // Flush FSM
   flush_state_e      state, state_next;
   logic [WALK_W-1:0] walk_idx;
   logic              fl_asid_en, fl_addr_en, walk_rd;
   logic [ASID_W-1:0] fl_asid;
   logic [31:12]      fl_addr;
   logic [SET_W-1:0]  walk_set;
   logic [SUP_W-1:0]  walk_sup;
   logic              walk_set_ok, walk_sup_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FS_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         FS_IDLE:  if (flush_req) state_next = FS_WALK;
         FS_WALK:  if (fl_addr_en || walk_idx == WALK_W'(WALK_N - 1)) state_next = FS_DRAIN;
         FS_DRAIN: state_next = FS_IDLE;
         default:  state_next = FS_IDLE;
      endcase
   end

   always_comb begin
      flush_busy  = (state != FS_IDLE);
      walk_rd     = (state == FS_WALK);
      flush_state = state;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         walk_idx   <= '0;
         fl_asid_en <= 1'b0;
         fl_addr_en <= 1'b0;
         fl_asid    <= '0;
         fl_addr    <= '0;
      end else if (state == FS_IDLE && flush_req) begin
         walk_idx   <= '0;
         fl_asid_en <= flush_asid_en;
         fl_addr_en <= flush_addr_en;
         fl_asid    <= flush_asid;
         fl_addr    <= flush_addr;
      end else if (walk_rd) begin
         walk_idx <= walk_idx + WALK_W'(1);
      end
   end

   // A full walk covers the larger array; indices past the smaller one are skipped.
   always_comb begin
      walk_set    = fl_addr_en ? fl_addr[12 +: SET_W] : walk_idx[SET_W-1:0];
      walk_sup    = fl_addr_en ? fl_addr[22 +: SUP_W] : walk_idx[SUP_W-1:0];
      walk_set_ok = fl_addr_en | ({1'b0, walk_idx} < (WALK_W + 1)'(SETS));
      walk_sup_ok = fl_addr_en | ({1'b0, walk_idx} < (WALK_W + 1)'(SUPER_SETS));
   end

   // RAM reads are registered, so the invalidate compare runs one cycle behind the walk;
   // DRAIN exists to finish the compare for the last index.
   logic              cmp_en, cmp_set_ok, cmp_sup_ok;
   logic [SET_W-1:0]  cmp_set;
   logic [SUP_W-1:0]  cmp_sup;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmp_en     <= 1'b0;
         cmp_set_ok <= 1'b0;
         cmp_sup_ok <= 1'b0;
         cmp_set    <= '0;
         cmp_sup    <= '0;
      end else begin
         cmp_en     <= walk_rd;
         cmp_set_ok <= walk_set_ok;
         cmp_sup_ok <= walk_sup_ok;
         cmp_set    <= walk_set;
         cmp_sup    <= walk_sup;
      end
   end

   // RAM: lookup read port, flush read port, write port (reads see pre-write data)
   entry_t            rd_ent  [WAYS];
   logic [ASID_W-1:0] rd_asid [WAYS];
   logic [SPPN_W-1:0] rd_sppn;
   logic [7:0]        rd_sflags;
   logic [ASID_W-1:0] rd_sasid;
   logic [TAG_W-1:0]  fl_tag  [WAYS];
   logic              fl_g    [WAYS];
   logic [ASID_W-1:0] fl_rasid [WAYS];
   logic              fl_sg;
   logic [ASID_W-1:0] fl_sasid;

   always_ff @(posedge clk) begin
      if (read_acc) begin
         for (int w = 0; w < WAYS; w++) begin
            rd_ent[w]  <= ram4k[rd_set_idx][w];
            rd_asid[w] <= asid4k[rd_set_idx][w];
         end
         rd_sppn   <= sup_ppn[rd_sup_idx];
         rd_sflags <= sup_flags[rd_sup_idx];
         rd_sasid  <= sup_asid[rd_sup_idx];
      end
      if (walk_rd) begin
         for (int w = 0; w < WAYS; w++) begin
            fl_tag[w]   <= ram4k[walk_set][w].tag;
            fl_g[w]     <= ram4k[walk_set][w].flags[FLAG_G];
            fl_rasid[w] <= asid4k[walk_set][w];
         end
         fl_sg    <= sup_flags[walk_sup][FLAG_G];
         fl_sasid <= sup_asid[walk_sup];
      end
      if (write_acc) begin
         if (write_super) begin
            sup_ppn[lk_sup]   <= write_ppn[28:22];
            sup_flags[lk_sup] <= write_flags;
            sup_asid[lk_sup]  <= write_asid;
         end else begin
            for (int w = 0; w < WAYS; w++) begin
               if (read_way[w]) begin
                  ram4k[lk_set][w]  <= '{tag: write_tag, ppn: write_ppn, flags: write_flags};
                  asid4k[lk_set][w] <= write_asid;
               end
            end
         end
      end
   end

   // Hit detection on the captured lookup
   logic [WAYS-1:0]  hit4, victim, way_sel;
   logic             sup_hit;
   logic [WAY_W-1:0] hit_idx;
   logic [WAYS-2:0]  plru_next;

   always_comb begin
      hit4    = '0;
      hit_idx = '0;
      for (int w = 0; w < WAYS; w++)
         hit4[w] = lk_valid_set[w] & (rd_ent[w].flags[FLAG_G] | (rd_asid[w] == lk_asid))
                 & (rd_ent[w].tag == lk_tag);
      for (int w = WAYS - 1; w >= 0; w--)
         if (hit4[w]) hit_idx = WAY_W'(w);
      sup_hit = lk_valid_sup & (rd_sflags[FLAG_G] | (rd_sasid == lk_asid));
   end

   plru_tree #(.WAYS(WAYS)) u_plru (
      .tree      (lk_plru),
      .access    (hit_idx),
      .victim    (victim),
      .tree_next (plru_next)
   );

   assign way_sel = (|hit4) ? hit4 : victim;

   always_comb begin
      read_hit   = 1'b0;
      read_super = 1'b0;
      read_ppn   = '0;
      read_flags = '0;
      read_way   = '0;
      if (result_valid) begin
         read_way = way_sel;
         if (sup_hit) begin
            read_hit   = 1'b1;
            read_super = 1'b1;
            read_ppn   = {rd_sppn, 10'b0};
            read_flags = rd_sflags;
         end else begin
            read_hit = |hit4;
            // Multiple hits (flagged below) produce the OR of the hit ways
            for (int w = 0; w < WAYS; w++) begin
               if (way_sel[w]) begin
                  read_ppn   = read_ppn | rd_ent[w].ppn;
                  read_flags = read_flags | rd_ent[w].flags;
               end
            end
         end
      end
   end

   a_single_hit: assert property (@(posedge clk) disable iff (reset) result_valid |-> $onehot0(hit4));

   // PLRU moves only on a 4K hit that the super array did not override
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) plru[s] <= '0;
      end else if (result_new && (|hit4) && !sup_hit) begin
         plru[lk_set] <= plru_next;
      end
   end

   // Flush invalidation
   logic [WAYS-1:0] clr4;
   logic            clr_s;
   always_comb begin
      for (int w = 0; w < WAYS; w++)
         clr4[w] = cmp_en & cmp_set_ok & valid4k[cmp_set][w]
                 & (!fl_asid_en | (!fl_g[w] & (fl_rasid[w] == fl_asid)))
                 & (!fl_addr_en | (fl_tag[w] == vpn_tag(fl_addr)));
      clr_s = cmp_en & cmp_sup_ok & valid_s[cmp_sup]
            & (!fl_asid_en | (!fl_sg & (fl_sasid == fl_asid)));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) valid4k[s] <= '0;
         valid_s <= '0;
      end else begin
         if (write_acc) begin
            if (write_super) valid_s[lk_sup] <= write_flags[FLAG_V];
            else
               for (int w = 0; w < WAYS; w++)
                  if (read_way[w]) valid4k[lk_set][w] <= write_flags[FLAG_V];
         end
         if (cmp_en) begin
            valid4k[cmp_set] <= valid4k[cmp_set] & ~clr4;
            if (clr_s) valid_s[cmp_sup] <= 1'b0;
         end
      end
   end

endmodule
